// File: rtl/ex_forward_ctrl_pkg.sv
// Shared types for the EX forwarding/hazard controller: register tags, select codes, match results.
package ex_forward_ctrl_pkg;
  localparam int REG_ADDR_W = 2;
  localparam int SEL_W      = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_IMM   = 2'b11
  } sel_e;

  // Fields needed to decide whether a slot produces a given source register.
  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] rd;
  } key_t;

  typedef struct packed {
    key_t key;
    logic is_load;
  } tag_t;

  typedef struct packed {
    sel_e sel;
    logic hazard;
  } match_t;

  function automatic logic key_hit(key_t k, logic [REG_ADDR_W-1:0] rs);
    return k.valid & k.wr_en & (k.rd == rs);
  endfunction
endpackage

// File: rtl/ex_forward_ctrl_fwd_match.sv
// Per-operand producer comparator. With FORWARDING_EN the nearest producer picks the
// bypass path and only a load in EX is a hazard; without it any in-flight producer stalls.
module fwd_match
  import ex_forward_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use,
  input  key_t                  i_ex,
  input  key_t                  i_mem,
`ifdef FORWARDING_EN
  input  logic                  i_ex_load,
`endif
  output match_t                o_match
);
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_use & key_hit(i_ex, i_rs);
  assign w_mem_hit = i_use & key_hit(i_mem, i_rs);

  always_comb begin
    o_match.sel    = SEL_RF;
    o_match.hazard = 1'b0;
`ifdef FORWARDING_EN
    // A load in EX has no data yet: it blocks the MEM-slot fallback too.
    if (w_ex_hit) begin
      if (i_ex_load) o_match.hazard = 1'b1;
      else           o_match.sel    = SEL_EXMEM;
    end else if (w_mem_hit) begin
      o_match.sel = SEL_MEMWB;
    end
`else
    o_match.hazard = w_ex_hit | w_mem_hit;
`endif
  end
endmodule

// File: rtl/ex_forward_ctrl.sv
// Forwarding and load-use hazard controller for the 8-bit pipeline (EX/MEM/WB tag pipe).
// Optional bypassing is enabled by defining FORWARDING_EN; otherwise hazards stall.
module ex_forward_ctrl
  import ex_forward_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs_a,
  input  logic [REG_ADDR_W-1:0] i_id_rs_b,
  input  logic                  i_id_use_a,
  input  logic                  i_id_use_b,
  input  logic                  i_id_imm_b,
  input  logic                  i_id_wr_en,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_fwd_a_s0,
  output logic                  o_fwd_a_s1,
  output logic                  o_fwd_b_s0,
  output logic                  o_fwd_b_s1,
  output logic                  o_ex_valid,
  output logic [7:0]            o_stall_cnt
);
  tag_t       r_ex, r_mem, r_wb;
  sel_e       r_sel_a, r_sel_b;
  logic       r_ex_valid;
  logic [7:0] r_stall_cnt;

  match_t w_ma, w_mb;
  logic   w_use_b, w_stall, w_adv;
  sel_e   w_sel_b;

  assign w_use_b = i_id_use_b & ~i_id_imm_b;

  fwd_match u_match_a (
    .i_rs      (i_id_rs_a),
    .i_use     (i_id_use_a),
    .i_ex      (r_ex.key),
    .i_mem     (r_mem.key),
`ifdef FORWARDING_EN
    .i_ex_load (r_ex.is_load),
`endif
    .o_match   (w_ma)
  );

  fwd_match u_match_b (
    .i_rs      (i_id_rs_b),
    .i_use     (w_use_b),
    .i_ex      (r_ex.key),
    .i_mem     (r_mem.key),
`ifdef FORWARDING_EN
    .i_ex_load (r_ex.is_load),
`endif
    .o_match   (w_mb)
  );

  assign w_stall = i_id_valid & ~i_flush & (w_ma.hazard | w_mb.hazard);
  assign w_adv   = i_id_valid & ~i_flush & ~w_stall;
  assign w_sel_b = i_id_imm_b ? SEL_IMM : w_mb.sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_sel_a     <= SEL_RF;
      r_sel_b     <= SEL_RF;
      r_ex_valid  <= 1'b0;
      r_stall_cnt <= 8'd0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      // Bubbles carry all-zero tags and selects so EX never sees stale routing.
      if (w_adv) begin
        r_ex.key.valid <= 1'b1;
        r_ex.key.wr_en <= i_id_wr_en;
        r_ex.key.rd    <= i_id_rd;
        r_ex.is_load   <= i_id_is_load;
        r_sel_a        <= w_ma.sel;
        r_sel_b        <= w_sel_b;
      end else begin
        r_ex    <= '0;
        r_sel_a <= SEL_RF;
        r_sel_b <= SEL_RF;
      end
      r_ex_valid <= w_adv;
      if (w_stall && r_stall_cnt != 8'hFF) r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign o_stall     = w_stall;
  assign o_fwd_a_s0  = r_sel_a[0];
  assign o_fwd_a_s1  = r_sel_a[1];
  assign o_fwd_b_s0  = r_sel_b[0];
  assign o_fwd_b_s1  = r_sel_b[1];
  assign o_ex_valid  = r_ex_valid;
  assign o_stall_cnt = r_stall_cnt;

  // The WB slot is architectural bookkeeping only: the RF write covers that case.
  a_rst_clear: assert property (@(posedge i_clk) i_rst |=> (r_wb == '0 && !r_ex_valid));
  a_no_imm_a:  assert property (@(posedge i_clk) disable iff (i_rst) r_sel_a != SEL_IMM);
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Bench for ex_forward_ctrl: directed table, saturation run and randomized reference-model check.
module tb_ex_forward_ctrl;
  import ex_forward_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_a, id_use_b, id_imm_b, id_wr_en, id_is_load, flush;
  logic [1:0] id_rs_a, id_rs_b, id_rd;
  logic       stall, fa0, fa1, fb0, fb1, ex_valid;
  logic [7:0] stall_cnt;

  always #5 clk = ~clk;

  ex_forward_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs_a(id_rs_a), .i_id_rs_b(id_rs_b),
    .i_id_use_a(id_use_a), .i_id_use_b(id_use_b), .i_id_imm_b(id_imm_b),
    .i_id_wr_en(id_wr_en), .i_id_rd(id_rd), .i_id_is_load(id_is_load),
    .i_flush(flush), .o_stall(stall),
    .o_fwd_a_s0(fa0), .o_fwd_a_s1(fa1), .o_fwd_b_s0(fb0), .o_fwd_b_s1(fb1),
    .o_ex_valid(ex_valid), .o_stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [1:0] ra; logic ua; logic [1:0] rb; logic ub; logic imm;
    logic wr; logic [1:0] rd; logic ld; logic fl;
  } in_t;
  typedef struct {
    in_t in; logic e_stall; logic [1:0] e_sa; logic [1:0] e_sb; logic e_exv;
  } vec_t;
  // Instructions that entered EX, indexed by age: 0 = now in EX, 1 = now in MEM.
  typedef struct { logic v; logic wr; logic ld; logic [1:0] rd; } prod_t;

  prod_t age [2];
  logic       m_exv;
  logic [1:0] m_sa, m_sb;
  int         m_cnt;
  int         n_chk = 0, n_fail = 0;
  logic       got_stall;
  vec_t       tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t ins(logic v, logic [1:0] ra, logic ua, logic [1:0] rb, logic ub,
                              logic imm, logic wr, logic [1:0] rd, logic ld, logic fl);
    in_t x;
    x.v = v; x.ra = ra; x.ua = ua; x.rb = rb; x.ub = ub; x.imm = imm;
    x.wr = wr; x.rd = rd; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic vec_t vec(in_t x, logic st, logic [1:0] sa, logic [1:0] sb, logic exv);
    vec_t r;
    r.in = x; r.e_stall = st; r.e_sa = sa; r.e_sb = sb; r.e_exv = exv;
    return r;
  endfunction

  function automatic in_t NOP();               return ins(0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic in_t ALU(logic [1:0] d);  return ins(1,0,0,0,0,0,1,d,0,0); endfunction
  function automatic in_t LD(logic [1:0] d);   return ins(1,0,0,0,0,0,1,d,1,0); endfunction
  function automatic in_t UA(logic [1:0] s);   return ins(1,s,1,0,0,0,0,0,0,0); endfunction
  function automatic in_t UB(logic [1:0] s);   return ins(1,0,0,s,1,0,0,0,0,0); endfunction

  // Operand decision from the rules: returns {hazard, select}.
  function automatic logic [2:0] op_eval(logic [1:0] rs, logic u);
    logic in_ex, in_mem;
    in_ex  = u && age[0].v && age[0].wr && age[0].rd == rs;
    in_mem = u && age[1].v && age[1].wr && age[1].rd == rs;
`ifdef FORWARDING_EN
    if (in_ex && age[0].ld) return 3'b100;
    if (in_ex)              return 3'b001;
    if (in_mem)             return 3'b010;
    return 3'b000;
`else
    return {in_ex || in_mem, 2'b00};
`endif
  endfunction

  task automatic cyc(input in_t x, input logic r);
    logic [2:0] ea, eb;
    logic st, adv;
    rst = r; id_valid = x.v; id_rs_a = x.ra; id_use_a = x.ua; id_rs_b = x.rb;
    id_use_b = x.ub; id_imm_b = x.imm; id_wr_en = x.wr; id_rd = x.rd;
    id_is_load = x.ld; flush = x.fl;
    #4;
    ea = op_eval(x.ra, x.ua);
    eb = op_eval(x.rb, x.ub && !x.imm);
    st = x.v && !x.fl && (ea[2] || eb[2]);
    adv = x.v && !x.fl && !st;
    got_stall = stall;
    if (!r) chk("stall", stall, st);
    @(posedge clk);
    if (r) begin
      age[0] = '{0,0,0,0}; age[1] = '{0,0,0,0};
      m_exv = 0; m_sa = 0; m_sb = 0; m_cnt = 0;
    end else begin
      age[1] = age[0];
      age[0] = '{adv, x.wr, x.ld, x.rd};
      m_exv = adv;
      m_sa = adv ? ea[1:0] : 2'b00;
      m_sb = adv ? (x.imm ? 2'b11 : eb[1:0]) : 2'b00;
      if (st && m_cnt < 255) m_cnt++;
    end
    #1;
    chk("ex_valid", ex_valid, m_exv);
    chk("sel_a", {fa1, fa0}, m_sa);
    chk("sel_b", {fb1, fb0}, m_sb);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_exv"}, ex_valid, 0);
    chk({nm, "_sela"}, {fa1, fa0}, 0);
    chk({nm, "_selb"}, {fb1, fb0}, 0);
    chk({nm, "_cnt"}, stall_cnt, 0);
    chk({nm, "_stall"}, stall, 0);
  endtask

  initial begin
    int k;
    in_t x;
    logic r;
    cyc(NOP(), 1);
    cyc(NOP(), 1);
    chk_reset_state("reset");

`ifdef FORWARDING_EN
    tbl.push_back(vec(ALU(1), 0, 0, 0, 1));
    tbl.push_back(vec(UA(1),  0, 1, 0, 1));  // ALU->ALU bypass from EX/MEM
    tbl.push_back(vec(ALU(2), 0, 0, 0, 1));
    tbl.push_back(vec(NOP(),  0, 0, 0, 0));
    tbl.push_back(vec(UB(2),  0, 0, 2, 1));  // one apart: MEM/WB path
    tbl.push_back(vec(ALU(2), 0, 0, 0, 1));
    tbl.push_back(vec(NOP(),  0, 0, 0, 0));
    tbl.push_back(vec(NOP(),  0, 0, 0, 0));
    tbl.push_back(vec(UB(2),  0, 0, 0, 1));  // three apart: register file
    tbl.push_back(vec(LD(3),  0, 0, 0, 1));
    tbl.push_back(vec(UA(3),  1, 0, 0, 0));  // load-use bubble
    tbl.push_back(vec(UA(3),  0, 2, 0, 1));
    tbl.push_back(vec(LD(1),  0, 0, 0, 1));
    tbl.push_back(vec(ins(1,1,1,0,0,0,0,0,0,1), 0, 0, 0, 0));  // flush beats stall
    tbl.push_back(vec(NOP(),  0, 0, 0, 0));
    tbl.push_back(vec(ALU(1), 0, 0, 0, 1));
    tbl.push_back(vec(ALU(1), 0, 0, 0, 1));
    tbl.push_back(vec(ins(1,1,1,1,1,1,0,0,0,0), 0, 1, 3, 1));  // nearest wins, imm on B
    k = 1;
`else
    tbl.push_back(vec(ALU(1), 0, 0, 0, 1));
    tbl.push_back(vec(UA(1),  1, 0, 0, 0));  // producer in EX
    tbl.push_back(vec(UA(1),  1, 0, 0, 0));  // producer in MEM
    tbl.push_back(vec(UA(1),  0, 0, 0, 1));
    tbl.push_back(vec(ALU(2), 0, 0, 0, 1));
    tbl.push_back(vec(NOP(),  0, 0, 0, 0));
    tbl.push_back(vec(UB(2),  1, 0, 0, 0));
    tbl.push_back(vec(UB(2),  0, 0, 0, 1));
    tbl.push_back(vec(LD(1),  0, 0, 0, 1));
    tbl.push_back(vec(ins(1,1,1,0,0,0,0,0,0,1), 0, 0, 0, 0));
    tbl.push_back(vec(ALU(1), 0, 0, 0, 1));
    tbl.push_back(vec(ins(1,0,0,1,1,1,0,0,0,0), 0, 0, 3, 1));  // imm masks the B match
    k = 3;
`endif
    foreach (tbl[i]) begin
      cyc(tbl[i].in, 0);
      chk($sformatf("tbl%0d_stall", i), got_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_exv", i), ex_valid, tbl[i].e_exv);
      chk($sformatf("tbl%0d_sa", i), {fa1, fa0}, tbl[i].e_sa);
      chk($sformatf("tbl%0d_sb", i), {fb1, fb0}, tbl[i].e_sb);
    end
    chk("tbl_stall_cnt", stall_cnt, k);

    for (int p = 0; p < 300; p++) begin
      cyc(LD(1), 0);
      k = 0;
      do begin
        cyc(UA(1), 0);
        k++;
      end while (got_stall && k < 4);
      if (got_stall) chk("loaduse_bound", 1, 0);
    end
    chk("stall_cnt_sat", stall_cnt, 255);

    cyc(LD(2), 0);
    cyc(UA(2), 1);
    chk_reset_state("midrst");

    for (int c = 0; c < 3000; c++) begin
      x = ins(($urandom % 4) != 0, 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
              ($urandom % 5) == 0, 1'($urandom), 2'($urandom), ($urandom % 3) == 0,
              ($urandom % 8) == 0);
      r = ($urandom % 200) == 0;
      cyc(x, r);
      if (r) chk_reset_state("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Forwarding and hazard controller for the 8-bit pipeline. It tracks destination-register tags of in-flight instructions through EX, MEM and WB. It drives the select pairs (s1,s0) of the two 8-bit 4:1 EX operand muxes and raises a load-use stall toward IF/ID. It sits between the ID stage and the ID/EX operand muxes; selects are registered so they are valid during the consumer's EX cycle.

## Interface
- REG_ADDR_W, 2: register-address width (4 architectural registers).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_a, id_rs_b  in  REG_ADDR_W  source register addresses.
- id_use_a, id_use_b  in  1  operand actually read from a register.
- id_imm_b  in  1  operand B is the immediate; overrides id_use_b.
- id_wr_en  in  1  instruction writes id_rd.
- id_rd  in  REG_ADDR_W  destination register.
- id_is_load  in  1  destination value comes from memory.
- flush  in  1  kill the instruction currently in ID (taken branch).
- stall  out  1  hold PC and IF/ID; combinational.
- fwd_a_s0, fwd_a_s1, fwd_b_s0, fwd_b_s1  out  1 each  operand mux selects, registered.
- ex_valid  out  1  EX holds a real instruction, registered.
- stall_cnt  out  8  saturating count of stall cycles.

## Operation
- Mux encoding {s1,s0}: 00 register-file value, 01 EX/MEM ALU result, 10 MEM/WB writeback value, 11 immediate (operand B only; A never receives 11).
- The register file is written on the edge ending WB and read in EX. A producer already in WB at the consumer's ID cycle needs no forwarding.
- Tag pipe: three slots (EX, MEM, WB), each holding {valid, wr_en, rd, is_load}. Every edge: WB<=MEM, MEM<=EX, and EX<=ID fields, or a bubble (valid=0) when stall or flush is active.
- Per operand, using ID-time slots:
  - EX-slot match (valid & wr_en & rd==rs) and not a load -> 01.
  - Else MEM-slot match -> 10.
  - Else 00.
  - The nearest producer wins.
- Load-use: an EX-slot match with is_load on a used operand -> stall=1 for one cycle and bubble inserted. Next cycle the load sits in MEM and the select resolves to 10.
- stall is qualified by id_valid and suppressed by flush. Flush overrides stall: bubble inserted, stall=0.
- Operands with use=0 never cause a match or a stall. id_imm_b forces B to 11.
- stall_cnt increments on every cycle with stall=1 and saturates at 255.

## Timing
- Selects and ex_valid are registered: values decided in ID cycle N appear in cycle N+1 (EX). Latency is 1 cycle.
- stall is combinational from ID inputs and tag state in the same cycle.
- Load-use costs exactly 1 bubble. ALU-to-ALU and load-to-next+1 dependences cost 0.
- Reset: all tag slots invalid, all selects 0, ex_valid=0, stall_cnt=0, stall=0.
- Reset mid-operation discards all tags. The first post-reset instruction sees no hazards.
- Simultaneous matches on A and B are resolved independently. A single stall covers both.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - Selects are always 00, or 11 for id_imm_b.
  - stall=1 whenever a used operand matches the EX or MEM slot (any producer type).
  - Effective penalties: 2 bubbles for a producer in EX, 1 bubble for a producer in MEM.
  - stall_cnt is still active.

## Structure
- Shared package: REG_ADDR_W, the select encodings (SEL_RF=00, SEL_EXMEM=01, SEL_MEMWB=10, SEL_IMM=11), and the tag-slot struct/field widths.
- One sub-module: fwd_match, a combinational per-operand comparator returning {select, load_hazard}. It is instantiated twice, for A and B.

## Test plan
- ADD R1 then SUB using R1 as A -> next EX cycle fwd_a={s1,s0}=01, stall never 1.
- ADD R2, NOP, then AND using R2 as B -> B select 10. Three apart -> 00.
- LOAD R3, then ADD using R3 as A -> stall=1 for exactly one cycle, ex_valid=0 in the bubble, then A select 10, stall_cnt=1.
- LOAD R1 with a taken-branch flush in the consumer's ID cycle -> stall=0, bubble inserted, stall_cnt unchanged.
- Both ADD R1 and ADD R1 in EX/MEM, consumer reading R1 -> select 01 (nearest wins). Operand B with id_imm_b=1 -> 11.
- Apply 300 back-to-back load-use pairs -> stall_cnt holds 255. Assert rst mid-stream -> all outputs 0 next cycle. With FORWARDING_EN undefined, the ADD R1 -> use R1 pair gives 2 stall cycles.
